instr_decode_stage: RTL and testbench
=====================================

# instr_decode_stage

Registered, parametrised instruction-decode pipeline stage between instruction fetch and the register file, ALU and I2C controller of the OLED processor. It splits each instruction word into its fields and issues them with a valid/ready handshake. It adds behaviour a purely combinational decoder lacks: single-cycle-latency issue with back-pressure, a blocking wait while an I2C transaction is in flight, a branch flush, RAW-hazard flagging and illegal-opcode detection.

## Interface
- OP_W, 5, opcode field width
- REG_W, 4, dest/src register-or-flag selector width
- IMM_W, 8, immediate field width
- ADDR_W, 8, memory address output width (imm field zero-extended or truncated to it)
- INSTR_W, OP_W+2*REG_W+IMM_W (21), instruction word width; layout [opcode | dest | src | imm], MSB first

Ports:
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_instr  in  INSTR_W  instruction word
- i_valid  in  1  i_instr valid
- o_ready  out  1  stage accepts i_instr this cycle
- i_flush  in  1  branch taken: discard held and incoming instructions
- o_valid  out  1  decoded outputs valid
- i_ready  in  1  downstream accepts outputs
- o_dest, o_src  out  REG_W  selectors
- o_imm  out  IMM_W  immediate, 0 unless opcode LSB = 1
- o_addr  out  ADDR_W  LOAD address, else 0
- o_alu_ctrl  out  3  ALU command
- o_rd_wen  out  1  register/flag write enable
- o_i2c_start  out  1  one-cycle pulse on handoff of an I2C instruction
- i_i2c_done  in  1  I2C controller finished
- o_hazard  out  1  src reads the dest of the immediately preceding write instruction
- o_illegal  out  1  opcode undefined; instruction issued as NOP

## Operation
- Opcodes: ADD 00000, SUB 00010, ADDI 00101, LOAD 01010, SETFLAG 10000, BEQ 10011, BEQF 10101, I2C 11000; all others illegal.
- alu_ctrl: ADD/ADDI 001, SUB 010, BEQ 011, BEQF 100; all others 000 (NOP).
- rd_wen = 1 for ADD, SUB, ADDI, LOAD, SETFLAG; 0 otherwise and for illegal.
- src = src field, except LOAD and illegal opcodes, where it is 0. dest = dest field (0 if illegal).
- imm = imm field when opcode LSB = 1, else 0. addr = imm field for LOAD only, else 0.
- Accept = i_valid && o_ready && !i_flush. On accept, all decoded outputs are registered and o_valid is set. Handoff = o_valid && i_ready.
- FSM has two states:
  - RUN: o_ready = !o_valid || i_ready. A handoff of an I2C opcode pulses o_i2c_start in that cycle, and the FSM enters WAIT next cycle.
  - WAIT: o_ready = 0. When i_i2c_done = 1, the FSM returns to RUN next cycle. i_i2c_done is ignored in RUN.
- Hazard tracker holds last_dest and last_wen of the most recently accepted instruction, updated on every accept. o_hazard registers (src-reading opcode: ADD, SUB, BEQ, BEQF) && last_wen && src == last_dest.
- i_flush: clears o_valid and last_wen next cycle and drops any same-cycle input (flush wins over accept). It does not leave WAIT. No o_i2c_start is generated for a flushed instruction.

## Timing
- Latency is 1 cycle, accept to o_valid. Throughput is 1 instruction/cycle with i_ready held high.
- Outputs hold stable while o_valid && !i_ready.
- o_i2c_start is combinational with handoff (o_valid && i_ready && held opcode = I2C).
- Minimum I2C blocking is 1 cycle of WAIT. i_i2c_done asserted in the first WAIT cycle gives o_ready = 1 in the following cycle.
- Reset: o_valid = 0, all data outputs 0, o_hazard = 0, o_illegal = 0, o_i2c_start = 0, FSM = RUN, last_wen = 0. Reset mid-WAIT returns the FSM to RUN, and any pending I2C done is ignored.

## Structure
- Package decoder_pkg: opcode localparams, ALU control codes, and a state enum for RUN/WAIT.
- Sub-module instr_field_decode: purely combinational field/opcode decode, parametrised identically. The stage holds the handshake, FSM, hazard tracker and output register.

## Test plan
- Stream ADD(dest3,src1), SUB(dest2,src4), ADDI(dest5,imm 0x2A) with i_ready = 1. Each appears 1 cycle after accept with alu_ctrl 001/010/001, wen 1, and ADDI imm 0x2A; ADD/SUB imm 0.
- ADD(dest3) then SUB(src3): SUB issues with o_hazard = 1. With a NOP inserted between them, o_hazard = 0.
- I2C instruction handed off: o_i2c_start pulses once and o_ready = 0 until 1 cycle after i_i2c_done, which is delayed 5 cycles. An i_i2c_done raised in RUN has no effect.
- Hold i_ready = 0 for 3 cycles with LOAD(imm 0x7C) valid. Outputs stay stable with addr 0x7C, src 0, wen 1, and o_ready = 0.
- i_flush in the same cycle as i_valid: the input is dropped and o_valid = 0 next cycle. The next instruction after a write shows no hazard.
- Opcode 11111 gives o_illegal = 1, alu_ctrl 000, wen 0. Asserting i_rst mid-WAIT gives all outputs 0 and o_ready = 1 next cycle.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared opcode, ALU-command and FSM-state definitions for the OLED
// processor instruction-decode stage.
package decoder_pkg;

  // Opcode encodings (5-bit opcode field).
  localparam logic [4:0] OP_ADD     = 5'b00000;
  localparam logic [4:0] OP_SUB     = 5'b00010;
  localparam logic [4:0] OP_ADDI    = 5'b00101;
  localparam logic [4:0] OP_LOAD    = 5'b01010;
  localparam logic [4:0] OP_SETFLAG = 5'b10000;
  localparam logic [4:0] OP_BEQ     = 5'b10011;
  localparam logic [4:0] OP_BEQF    = 5'b10101;
  localparam logic [4:0] OP_I2C     = 5'b11000;

  // ALU command codes.
  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_BEQ  = 3'b011;
  localparam logic [2:0] ALU_BEQF = 3'b100;

  // Issue FSM: RUN issues freely, WAIT blocks while an I2C transfer runs.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of an instruction word into its fields and
// opcode-derived control signals. Illegal opcodes decode as a NOP.
module instr_field_decode
  import decoder_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int REG_W   = 4,
  parameter int IMM_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = OP_W + 2*REG_W + IMM_W
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_W-1:0]   dest,
  output logic [REG_W-1:0]   src,
  output logic [IMM_W-1:0]   imm,
  output logic [ADDR_W-1:0]  addr,
  output logic [2:0]         alu_ctrl,
  output logic               rd_wen,
  output logic               src_read,
  output logic               is_i2c,
  output logic               illegal
);

  logic [OP_W-1:0]  op_field;
  logic [REG_W-1:0] dest_field;
  logic [REG_W-1:0] src_field;
  logic [IMM_W-1:0] imm_field;

  assign {op_field, dest_field, src_field, imm_field} = instr;

  // Opcode-driven control decode.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    dest     = dest_field;
    src      = src_field;
    imm      = op_field[0] ? imm_field : '0;
    addr     = '0;
    alu_ctrl = ALU_NOP;
    rd_wen   = 1'b0;
    src_read = 1'b0;
    is_i2c   = 1'b0;
    illegal  = 1'b0;
    case (op_field)
      OP_ADD:     begin alu_ctrl = ALU_ADD;  rd_wen = 1'b1; src_read = 1'b1; end
      OP_SUB:     begin alu_ctrl = ALU_SUB;  rd_wen = 1'b1; src_read = 1'b1; end
      OP_ADDI:    begin alu_ctrl = ALU_ADD;  rd_wen = 1'b1; end
      OP_LOAD:    begin rd_wen = 1'b1; src = '0; addr = ADDR_W'(imm_field); end
      OP_SETFLAG: rd_wen = 1'b1;
      OP_BEQ:     begin alu_ctrl = ALU_BEQ;  src_read = 1'b1; end
      OP_BEQF:    begin alu_ctrl = ALU_BEQF; src_read = 1'b1; end
      OP_I2C:     is_i2c = 1'b1;
      default: begin
        illegal = 1'b1;
        dest    = '0;
        src     = '0;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage: valid/ready issue with one cycle of
// latency, I2C blocking wait, branch flush, RAW hazard flag and illegal
// opcode detection.
module instr_decode_stage
  import decoder_pkg::*;
#(
  parameter int OP_W    = 5,
  parameter int REG_W   = 4,
  parameter int IMM_W   = 8,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = OP_W + 2*REG_W + IMM_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [REG_W-1:0]   o_dest,
  output logic [REG_W-1:0]   o_src,
  output logic [IMM_W-1:0]   o_imm,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [2:0]         o_alu_ctrl,
  output logic               o_rd_wen,
  output logic               o_i2c_start,
  input  logic               i_i2c_done,
  output logic               o_hazard,
  output logic               o_illegal
);

  logic [REG_W-1:0]  dec_dest;
  logic [REG_W-1:0]  dec_src;
  logic [IMM_W-1:0]  dec_imm;
  logic [ADDR_W-1:0] dec_addr;
  logic [2:0]        dec_alu_ctrl;
  logic              dec_rd_wen;
  logic              dec_src_read;
  logic              dec_is_i2c;
  logic              dec_illegal;

  instr_field_decode #(
    .OP_W(OP_W), .REG_W(REG_W), .IMM_W(IMM_W), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)
  ) u_decode (
    .instr    (i_instr),
    .dest     (dec_dest),
    .src      (dec_src),
    .imm      (dec_imm),
    .addr     (dec_addr),
    .alu_ctrl (dec_alu_ctrl),
    .rd_wen   (dec_rd_wen),
    .src_read (dec_src_read),
    .is_i2c   (dec_is_i2c),
    .illegal  (dec_illegal)
  );

  state_t           state_q, state_d;
  logic             held_i2c;
  logic [REG_W-1:0] last_dest;
  logic             last_wen;
  logic             accept;
  logic             handoff;
  logic             raw_hazard;

  // Flush wins over a same-cycle accept.
  assign accept     = i_valid && o_ready && !i_flush;
  assign handoff    = o_valid && i_ready;
  assign raw_hazard = dec_src_read && last_wen && (dec_src == last_dest);

  // FSM next state, ready and I2C start pulse.
  always_comb begin
    state_d     = state_q;
    o_ready     = 1'b0;
    o_i2c_start = 1'b0;
    case (state_q)
      ST_RUN: begin
        o_ready = !o_valid || i_ready;
        // A flushed I2C instruction must never start a transfer.
        if (handoff && held_i2c && !i_flush) begin
          o_i2c_start = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_i2c_done) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (i_rst) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Hazard tracker: destination and write-enable of the last accepted instruction.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_dest <= '0;
      last_wen  <= 1'b0;
    end else if (i_flush) begin
      last_wen  <= 1'b0;
    end else if (accept) begin
      last_dest <= dec_dest;
      last_wen  <= dec_rd_wen;
    end
  end

  // Output register: load on accept, drop valid on handoff or flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid    <= 1'b0;
      o_dest     <= '0;
      o_src      <= '0;
      o_imm      <= '0;
      o_addr     <= '0;
      o_alu_ctrl <= ALU_NOP;
      o_rd_wen   <= 1'b0;
      o_hazard   <= 1'b0;
      o_illegal  <= 1'b0;
      held_i2c   <= 1'b0;
    end else if (i_flush) begin
      o_valid    <= 1'b0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_dest     <= dec_dest;
      o_src      <= dec_src;
      o_imm      <= dec_imm;
      o_addr     <= dec_addr;
      o_alu_ctrl <= dec_alu_ctrl;
      o_rd_wen   <= dec_rd_wen;
      o_hazard   <= raw_hazard;
      o_illegal  <= dec_illegal;
      held_i2c   <= dec_is_i2c;
    end else if (handoff) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage.
module tb_instr_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [20:0] i_instr;
  logic        i_valid;
  logic        o_ready;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_dest;
  logic [3:0]  o_src;
  logic [7:0]  o_imm;
  logic [7:0]  o_addr;
  logic [2:0]  o_alu_ctrl;
  logic        o_rd_wen;
  logic        o_i2c_start;
  logic        i_i2c_done;
  logic        o_hazard;
  logic        o_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  instr_decode_stage dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_instr     (i_instr),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_dest      (o_dest),
    .o_src       (o_src),
    .o_imm       (o_imm),
    .o_addr      (o_addr),
    .o_alu_ctrl  (o_alu_ctrl),
    .o_rd_wen    (o_rd_wen),
    .o_i2c_start (o_i2c_start),
    .i_i2c_done  (i_i2c_done),
    .o_hazard    (o_hazard),
    .o_illegal   (o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] mk(input logic [4:0] op, input logic [3:0] d,
                                     input logic [3:0] s, input logic [7:0] imm);
    return {op, d, s, imm};
  endfunction

  // Advance past the next rising edge; outputs are then sampled 1 ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Wait inside the current cycle before sampling combinational outputs.
  task automatic settle();
    #2;
  endtask

  initial begin
    i_rst = 1'b1; i_instr = '0; i_valid = 1'b0; i_flush = 1'b0;
    i_ready = 1'b1; i_i2c_done = 1'b0;
    tick(); tick();
    check("rst_valid", o_valid, 0);
    check("rst_dest", o_dest, 0);
    check("rst_alu", o_alu_ctrl, 0);
    check("rst_wen", o_rd_wen, 0);
    check("rst_hazard", o_hazard, 0);
    check("rst_illegal", o_illegal, 0);
    i_rst = 1'b0;
    settle();
    check("rst_ready", o_ready, 1);

    // Streaming ADD, SUB, ADDI with i_ready high.
    i_valid = 1'b1;
    i_instr = mk(5'b00000, 4'd3, 4'd1, 8'h11);
    tick();
    check("add_valid", o_valid, 1);
    check("add_dest", o_dest, 3);
    check("add_src", o_src, 1);
    check("add_alu", o_alu_ctrl, 3'b001);
    check("add_wen", o_rd_wen, 1);
    check("add_imm", o_imm, 0);
    check("add_hazard", o_hazard, 0);
    i_instr = mk(5'b00010, 4'd2, 4'd4, 8'h00);
    tick();
    check("sub_valid", o_valid, 1);
    check("sub_dest", o_dest, 2);
    check("sub_src", o_src, 4);
    check("sub_alu", o_alu_ctrl, 3'b010);
    check("sub_hazard", o_hazard, 0);
    i_instr = mk(5'b00101, 4'd5, 4'd0, 8'h2A);
    tick();
    check("addi_dest", o_dest, 5);
    check("addi_alu", o_alu_ctrl, 3'b001);
    check("addi_wen", o_rd_wen, 1);
    check("addi_imm", o_imm, 8'h2A);
    i_valid = 1'b0;
    tick();
    check("bubble_valid", o_valid, 0);

    // RAW hazard: ADD d3 then SUB s3.
    i_valid = 1'b1;
    i_instr = mk(5'b00000, 4'd3, 4'd1, 8'h00);
    tick();
    i_instr = mk(5'b00010, 4'd2, 4'd3, 8'h00);
    tick();
    check("raw_hazard", o_hazard, 1);
    // ADD d3, illegal NOP, SUB s3: no hazard.
    i_instr = mk(5'b00000, 4'd3, 4'd1, 8'h00);
    tick();
    i_instr = mk(5'b00001, 4'd3, 4'd3, 8'h00);
    tick();
    check("nop_illegal", o_illegal, 1);
    check("nop_wen", o_rd_wen, 0);
    i_instr = mk(5'b00010, 4'd2, 4'd3, 8'h00);
    tick();
    check("gap_hazard", o_hazard, 0);
    check("gap_illegal", o_illegal, 0);
    i_valid = 1'b0;
    tick();

    // i2c_done while in RUN has no effect.
    i_i2c_done = 1'b1;
    tick();
    i_i2c_done = 1'b0;
    settle();
    check("done_in_run_ready", o_ready, 1);

    // I2C handoff and blocking wait.
    i_valid = 1'b1;
    i_instr = mk(5'b11000, 4'd0, 4'd0, 8'h00);
    tick();
    i_valid = 1'b0;
    check("i2c_valid", o_valid, 1);
    check("i2c_wen", o_rd_wen, 0);
    settle();
    check("i2c_start_pulse", o_i2c_start, 1);
    tick();
    check("i2c_wait_valid", o_valid, 0);
    check("i2c_start_once", o_i2c_start, 0);
    check("i2c_wait_ready0", o_ready, 0);
    for (int i = 0; i < 4; i++) tick();
    check("i2c_wait_ready4", o_ready, 0);
    i_i2c_done = 1'b1;
    settle();
    check("i2c_done_cycle_ready", o_ready, 0);
    tick();
    i_i2c_done = 1'b0;
    check("i2c_after_done_ready", o_ready, 1);
    check("i2c_after_start", o_i2c_start, 0);

    // Back-pressure hold with LOAD.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_instr = mk(5'b01010, 4'd6, 4'd9, 8'h7C);
    tick();
    i_instr = mk(5'b00000, 4'd1, 4'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", o_valid, 1);
      check("hold_addr", o_addr, 8'h7C);
      check("hold_src", o_src, 0);
      check("hold_dest", o_dest, 6);
      check("hold_wen", o_rd_wen, 1);
      check("hold_imm", o_imm, 0);
      check("hold_ready", o_ready, 0);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    check("hold_release_valid", o_valid, 0);

    // Flush drops a same-cycle input and clears the hazard tracker.
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_instr = mk(5'b00010, 4'd1, 4'd6, 8'h00);
    tick();
    i_flush = 1'b0;
    check("flush_drop_valid", o_valid, 0);
    tick();
    check("post_flush_valid", o_valid, 1);
    check("post_flush_hazard", o_hazard, 0);

    // Illegal opcode 11111.
    i_instr = mk(5'b11111, 4'd7, 4'd7, 8'h00);
    tick();
    i_valid = 1'b0;
    check("ill_illegal", o_illegal, 1);
    check("ill_alu", o_alu_ctrl, 0);
    check("ill_wen", o_rd_wen, 0);
    check("ill_dest", o_dest, 0);
    check("ill_src", o_src, 0);
    tick();

    // Reset while waiting on I2C.
    i_valid = 1'b1;
    i_instr = mk(5'b11000, 4'd0, 4'd0, 8'h00);
    tick();
    i_valid = 1'b0;
    tick();
    check("rw_wait_ready", o_ready, 0);
    i_rst = 1'b1;
    i_i2c_done = 1'b1;
    tick();
    i_rst = 1'b0;
    i_i2c_done = 1'b0;
    check("rw_valid", o_valid, 0);
    check("rw_alu", o_alu_ctrl, 0);
    check("rw_hazard", o_hazard, 0);
    check("rw_illegal", o_illegal, 0);
    settle();
    check("rw_ready", o_ready, 1);
    check("rw_start", o_i2c_start, 0);
    tick();
    check("rw_ready_next", o_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
